num_display_scan: RTL and testbench

//   Output end of the 8-digit hex number path: takes a 32-bit value (8 nibbles) and drives a

---
 rtl/num_disp_pkg.sv | 21 ++
 rtl/hex_to_seg7.sv | 9 +
 rtl/num_display_scan.sv | 76 +++++++
 tb/tb_num_display_scan.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/num_disp_pkg.sv
// Shared constants for the 8-digit seven-segment scan path.
// Segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}.
package num_disp_pkg;
  localparam int DIGITS = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // gfedcba patterns, entry 15 first so SEG_LUT[n] is the glyph for hex digit n
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low gfedcba pattern.
module hex_to_seg7
  import num_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7
);
  assign seg7 = SEG_LUT[nibble];
endmodule

// File: rtl/num_display_scan.sv
// Double-buffered 8-digit common-anode hex display scanner with per-slot blanking.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module num_display_scan
  import num_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 25000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] number,
  input  logic        load,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [39:0]   pending, shadow;

  logic       slot_end, frame_end;
  logic [3:0] nib;
  logic       dp_bit;
  logic [6:0] seg7;
  logic       in_blank, lz_blank;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IW'(DIGITS - 1));
  assign nib       = shadow[{idx, 2'b00} +: 4];
  assign dp_bit    = shadow[32 + int'(idx)];
  assign in_blank  = (cnt < BLANK_LIM);

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is leading when it and everything to its left is zero and its dp is off
  assign lz_blank = (idx != '0) && ((shadow[31:0] >> {idx, 2'b00}) == 32'd0) && !dp_bit;
`else
  assign lz_blank = 1'b0;
`endif

  hex_to_seg7 u_hex (
    .nibble (nib),
    .seg7   (seg7)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      shadow     <= '0;
      an         <= SEG_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx + 1'b1;
      if (load) pending <= {dp_mask, number};
      // Commit only at the frame wrap; a coincident load bypasses the pending buffer
      if (frame_end) shadow <= load ? {dp_mask, number} : pending;
      frame_done <= frame_end;
      if (in_blank || lz_blank) begin
        an  <= SEG_OFF;
        seg <= SEG_OFF;
      end else begin
        an  <= ~(8'b1 << idx);
        seg <= {~dp_bit, seg7};
      end
    end
  end
endmodule

// File: tb/tb_num_display_scan.sv
// Scoreboard bench for num_display_scan at SCAN_DIV=4, BLANK_CYCLES=1 (32-cycle frames).
module tb_num_display_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [31:0] number = '0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  an, seg;
  logic        frame_done;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] sb[$];
  logic [39:0] m_pend = '0;
  logic [39:0] m_shadow = '0;
  int   mcyc;
  logic prev_blank = 1'b1;

  localparam logic [7:0] LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  num_display_scan #(.SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .number     (number),
    .load       (load),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the eight digit slots the current model shadow should produce
  task automatic push_frame();
    for (int d = 0; d < 8; d++) begin
      logic [3:0] nib;
      logic       dp;
      logic [7:0] ea, es, lut;
      logic [31:0] num;
      logic       skip;
      num  = m_shadow[31:0];
      nib  = num[4*d +: 4];
      dp   = m_shadow[32 + d];
      lut  = LUT[nib];
      ea   = ~(8'b1 << d);
      es   = {~dp, lut[6:0]};
      skip = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && (num >> (4 * d)) == 32'd0 && !dp) skip = 1'b1;
`endif
      if (!skip) sb.push_back({ea, es});
    end
  endtask

  // One full frame starting at the negedge of its first cycle; up to two loads at given offsets
  task automatic frame(input int o1, input logic [31:0] n1, input logic [7:0] d1,
                       input int o2, input logic [31:0] n2, input logic [7:0] d2);
    m_shadow = m_pend;
    push_frame();
    for (int off = 0; off < 32; off++) begin
      if (off == o1) begin
        number = n1; dp_mask = d1; load = 1'b1; m_pend = {d1, n1};
      end else if (off == o2) begin
        number = n2; dp_mask = d2; load = 1'b1; m_pend = {d2, n2};
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) mcyc <= 0;
    else     mcyc <= mcyc + 1;
  end

  // Monitor: one scoreboard entry per lit slot, plus blank-slot and frame_done checks
  always @(negedge clk) begin
    if (rst) begin
      prev_blank = 1'b1;
    end else begin
      if (mcyc % 4 == 1) check("slot_blank", {an, seg}, 16'hFFFF);
      if (an != 8'hFF) begin
        check("an_onehot", $countones(~an), 1);
        if (prev_blank) begin
          if (sb.size() == 0) begin
            check("sb_underflow", {an, seg}, 16'h0000);
          end else begin
            logic [15:0] e;
            e = sb.pop_front();
            check("digit", {an, seg}, e);
          end
        end
      end
      if (frame_done || (mcyc % 32 == 0 && mcyc > 0))
        check("frame_done", frame_done, (mcyc % 32 == 0 && mcyc > 0));
      prev_blank = (an == 8'hFF);
    end
  end

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    check("rst_fd", frame_done, 0);
    rst = 1'b0;

    // frame 0 shows reset zeros; mid-frame load must wait for the wrap
    frame(10, 32'h89ABCDEF, 8'h00, -1, 32'h0, 8'h00);
    // frame 1 shows 89ABCDEF; load coincident with the wrap
    frame(31, 32'h00000001, 8'h00, -1, 32'h0, 8'h00);
    // frame 2 shows 00000001; back-to-back loads, last wins
    frame(5, 32'h00000001, 8'h00, 6, 32'h00000002, 8'h00);
    // frame 3 shows 00000002
    frame(20, 32'h00000120, 8'h10, 31, 32'h00000120, 8'h10);
    // frame 4 shows 00000120 with dp on digit 4
    frame(31, 32'h12345678, 8'hA5, -1, 32'h0, 8'h00);

    // frame 5: reset hits during digit 5
    m_shadow = m_pend;
    push_frame();
    repeat (22) @(negedge clk);
    check("pre_rst_an", an, 8'hDF);
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", an, 8'hFF);
    check("async_rst_seg", seg, 8'hFF);
    check("async_rst_fd", frame_done, 0);
    sb.delete();
    m_pend = '0;
    m_shadow = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // scan restarts at digit 0 with a cleared shadow
    frame(-1, 32'h0, 8'h00, -1, 32'h0, 8'h00);
    frame(-1, 32'h0, 8'h00, -1, 32'h0, 8'h00);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
